// File: rtl/kicp_pkg.sv
// Shared KICP definitions: accelerator memory-protocol op codes and SRAM arbiter states.
`ifndef KICP_SRAM_AWIDTH
`define KICP_SRAM_AWIDTH 12
`endif

package kicp_pkg;

  localparam logic [1:0] MEM_OP_NONE  = 2'b00;
  localparam logic [1:0] MEM_OP_READ  = 2'b01;
  localparam logic [1:0] MEM_OP_WRITE = 2'b11;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_ISSUE = 2'b01,
    ARB_WAIT  = 2'b10,
    ARB_RESP  = 2'b11
  } arb_state_e;

  // 2'b10 is reserved and behaves like no request.
  function automatic logic op_is_req(input logic [1:0] op);
    return (op == MEM_OP_READ) || (op == MEM_OP_WRITE);
  endfunction

endpackage

// File: rtl/kicp_arb_rr2.sv
// Combinational 2-way winner select; round-robin on last_grant, or fixed port-0
// priority when KICP_ARB_FIXED_PRIO_EN is defined (last_grant port then absent).
module kicp_arb_rr2 (
  input  logic       req0,
  input  logic       req1,
`ifndef KICP_ARB_FIXED_PRIO_EN
  input  logic       last_grant,
`endif
  output logic [1:0] winner
);

  always_comb begin
    winner = 2'b00;
    if (req0 && req1) begin
`ifdef KICP_ARB_FIXED_PRIO_EN
      winner = 2'b01;
`else
      // Contention goes to the port that was not served most recently.
      winner = last_grant ? 2'b01 : 2'b10;
`endif
    end else if (req0) begin
      winner = 2'b01;
    end else if (req1) begin
      winner = 2'b10;
    end
  end

endmodule

// File: rtl/kicp_sram_arbiter.sv
// Two-port SRAM arbiter, one access in flight; write 3 cycles, read 3+RD_LATENCY cycles.
// Requesters hold their request until opdone; KICP_ARB_FIXED_PRIO_EN selects fixed port-0 priority.
`ifndef KICP_SRAM_AWIDTH
`define KICP_SRAM_AWIDTH 12
`endif

module kicp_sram_arbiter import kicp_pkg::*; #(
  parameter int AWIDTH     = `KICP_SRAM_AWIDTH,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        p0_op,
  input  logic [AWIDTH-1:0] p0_addr,
  input  logic [31:0]       p0_wdata,
  input  logic [1:0]        p1_op,
  input  logic [AWIDTH-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  output logic              p0_opdone,
  output logic [31:0]       p0_rdata,
  output logic              p1_opdone,
  output logic [31:0]       p1_rdata,
  output logic              sram_en,
  output logic              sram_we,
  output logic [AWIDTH-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output logic [1:0]        grant,
  output logic              busy
);

  localparam int CW = 2;

  arb_state_e      state;
  arb_state_e      state_next;
  logic [1:0]      winner;
  logic            op_we;
  logic [CW-1:0]   cnt;

`ifdef KICP_ARB_FIXED_PRIO_EN
  kicp_arb_rr2 u_rr2 (
    .req0   (op_is_req(p0_op)),
    .req1   (op_is_req(p1_op)),
    .winner (winner)
  );
`else
  logic last_grant;

  kicp_arb_rr2 u_rr2 (
    .req0       (op_is_req(p0_op)),
    .req1       (op_is_req(p1_op)),
    .last_grant (last_grant),
    .winner     (winner)
  );
`endif

  always_comb begin
    state_next = state;
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    p0_opdone  = 1'b0;
    p1_opdone  = 1'b0;
    busy       = (state != ARB_IDLE);
    case (state)
      ARB_IDLE: begin
        if (winner != 2'b00) state_next = ARB_ISSUE;
      end
      ARB_ISSUE: begin
        sram_en    = 1'b1;
        sram_we    = op_we;
        state_next = op_we ? ARB_RESP : ARB_WAIT;
      end
      ARB_WAIT: begin
        if (cnt == '0) state_next = ARB_RESP;
      end
      ARB_RESP: begin
        p0_opdone  = grant[0];
        p1_opdone  = grant[1];
        state_next = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB_IDLE;
      grant      <= 2'b00;
      op_we      <= 1'b0;
      cnt        <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
`ifndef KICP_ARB_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
    end else begin
      state <= state_next;
      case (state)
        ARB_IDLE: begin
          if (winner != 2'b00) begin
            grant      <= winner;
            op_we      <= winner[0] ? (p0_op == MEM_OP_WRITE) : (p1_op == MEM_OP_WRITE);
            sram_addr  <= winner[0] ? p0_addr  : p1_addr;
            sram_wdata <= winner[0] ? p0_wdata : p1_wdata;
`ifndef KICP_ARB_FIXED_PRIO_EN
            last_grant <= winner[1];
`endif
          end
        end
        ARB_ISSUE: cnt <= CW'(RD_LATENCY - 1);
        ARB_WAIT: begin
          cnt <= cnt - 1'b1;
          // Last wait cycle is exactly RD_LATENCY cycles after the strobe.
          if (cnt == '0) begin
            if (grant[0]) p0_rdata <= sram_rdata;
            if (grant[1]) p1_rdata <= sram_rdata;
          end
        end
        ARB_RESP: grant <= 2'b00;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kicp_sram_arbiter.sv
// Scoreboard bench for kicp_sram_arbiter: main instance at RD_LATENCY=1 plus one read-only
// instance per RD_LATENCY 2..4.
module tb_kicp_sram_arbiter;

  localparam int AW = 8;
  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            lat_reset;
  logic [1:0]      p0_op, p1_op;
  logic [AW-1:0]   p0_addr, p1_addr;
  logic [31:0]     p0_wdata, p1_wdata;
  logic            p0_opdone, p1_opdone;
  logic [31:0]     p0_rdata, p1_rdata;
  logic            sram_en, sram_we;
  logic [AW-1:0]   sram_addr;
  logic [31:0]     sram_wdata, sram_rdata;
  logic [1:0]      grant;
  logic            busy;

  kicp_sram_arbiter #(.AWIDTH(AW), .RD_LATENCY(1)) u_dut (
    .clk(clk), .reset(reset),
    .p0_op(p0_op), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_op(p1_op), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_opdone(p0_opdone), .p0_rdata(p0_rdata),
    .p1_opdone(p1_opdone), .p1_rdata(p1_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .grant(grant), .busy(busy)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int done_cnt0 = 0;
  int done_cnt1 = 0;
  int lane_fin = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] init_word(input logic [AW-1:0] a);
    return (a == AW'(5)) ? 32'hDEADBEEF : {16'hC0DE, 8'h00, a};
  endfunction

  // SRAM model: data is valid only in the cycle RD_LATENCY after the strobe.
  logic [31:0] mem_wr [256];
  bit          mem_vld [256];
  always @(posedge clk) begin
    sram_rdata <= JUNK;
    if (sram_en && sram_we) begin
      mem_wr[sram_addr]  <= sram_wdata;
      mem_vld[sram_addr] <= 1'b1;
    end
    if (sram_en && !sram_we)
      sram_rdata <= mem_vld[sram_addr] ? mem_wr[sram_addr] : init_word(sram_addr);
  end

  // Reference memory, updated when a write is presented.
  logic [31:0] ref_wr [256];
  bit          ref_vld [256];

  typedef struct { bit rd; logic [31:0] data; } exp_t;
  exp_t exp_q0[$];
  exp_t exp_q1[$];

  typedef struct { logic [1:0] gnt; logic we; logic [AW-1:0] addr; } acc_t;
  acc_t acc_q[$];

  always @(negedge clk) begin
    exp_t e;
    if (sram_en) acc_q.push_back('{gnt: grant, we: sram_we, addr: sram_addr});
    if (p0_opdone) begin
      done_cnt0++;
      if (exp_q0.size() == 0) chk("p0_spurious_opdone", exp_q0.size(), 1);
      else begin
        e = exp_q0.pop_front();
        if (e.rd) chk("p0_rdata", p0_rdata, e.data);
      end
    end
    if (p1_opdone) begin
      done_cnt1++;
      if (exp_q1.size() == 0) chk("p1_spurious_opdone", exp_q1.size(), 1);
      else begin
        e = exp_q1.pop_front();
        if (e.rd) chk("p1_rdata", p1_rdata, e.data);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic present(input int p, input logic [1:0] op, input logic [AW-1:0] a,
                         input logic [31:0] d);
    exp_t e;
    e.rd   = (op == 2'b01);
    e.data = ref_vld[a] ? ref_wr[a] : init_word(a);
    if (op == 2'b11) begin
      ref_wr[a]  = d;
      ref_vld[a] = 1'b1;
    end
    if (p == 0) begin
      p0_op = op; p0_addr = a; p0_wdata = d; exp_q0.push_back(e);
    end else begin
      p1_op = op; p1_addr = a; p1_wdata = d; exp_q1.push_back(e);
    end
  endtask

  task automatic wait_done(input int p, output int at);
    at = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((p == 0 && p0_opdone) || (p == 1 && p1_opdone)) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic read_one(input int p, input logic [AW-1:0] a, input string tag);
    int n;
    int at;
    n = cyc;
    present(p, 2'b01, a, 32'h0);
    wait_done(p, at);
    chk(tag, at - n, 3);
    @(posedge clk); #1;
    if (p == 0) p0_op = 2'b00; else p1_op = 2'b00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    p0_op = 2'b00;
    p1_op = 2'b00;
    tick(2);
    reset = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    tick(1);
  endtask

  initial begin
    int n, a0, a1, at, d0, d1, tot;
    logic c0, c1;
    logic [AW-1:0] t0, t1;
    logic [1:0] eg;
    reset = 1'b1; lat_reset = 1'b1;
    p0_op = 2'b00; p1_op = 2'b00; p0_addr = '0; p1_addr = '0;
    p0_wdata = '0; p1_wdata = '0;

    // Reset state
    tick(3);
    lat_reset = 1'b0;
    @(negedge clk);
    chk("reset_ctrl", {sram_en, sram_we, p0_opdone, p1_opdone, busy, grant}, 7'b0);
    chk("reset_sram_regs", {sram_addr, sram_wdata}, 40'h0);
    chk("reset_rdata", {p0_rdata, p1_rdata}, 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick(1);

    // Single read on port 1
    acc_q.delete();
    d0 = done_cnt0;
    n = cyc;
    present(1, 2'b01, AW'(5), 32'h0);
    wait_done(1, at);
    chk("t1_read_lat", at - n, 3);
    @(posedge clk); #1;
    p1_op = 2'b00;
    tick(3);
    chk("t1_strobes", acc_q.size(), 1);
    if (acc_q.size() > 0) chk("t1_strobe_we_addr", {acc_q[0].we, acc_q[0].addr}, {1'b0, AW'(5)});
    chk("t1_p0_opdones", done_cnt0 - d0, 0);
    chk("t1_rdata_held", p1_rdata, init_word(AW'(5)));

    // Simultaneous writes from reset: port 0 first
    do_reset();
    acc_q.delete();
    n = cyc;
    present(0, 2'b11, AW'(1), 32'h11);
    present(1, 2'b11, AW'(2), 32'h22);
    fork
      begin wait_done(0, a0); @(posedge clk); #1; p0_op = 2'b00; end
      begin wait_done(1, a1); @(posedge clk); #1; p1_op = 2'b00; end
    join
    chk("t2_p0_lat", a0 - n, 2);
    chk("t2_p1_lat", a1 - n, 5);
    chk("t2_strobes", acc_q.size(), 2);
    if (acc_q.size() > 1) chk("t2_order", {acc_q[0].gnt, acc_q[1].gnt}, 4'b0110);
    chk("t2_mem1", mem_wr[1], 32'h11);
    chk("t2_mem2", mem_wr[2], 32'h22);
    read_one(1, AW'(1), "t2_rb1_lat");
    read_one(1, AW'(2), "t2_rb2_lat");

    // Continuous reads from both ports, 8 accesses
    acc_q.delete();
    d0 = done_cnt0; d1 = done_cnt1; tot = 0;
    t0 = AW'(10); t1 = AW'(20);
    present(0, 2'b01, t0, 32'h0);
    present(1, 2'b01, t1, 32'h0);
    for (int i = 0; i < 200 && tot < 8; i++) begin
      @(negedge clk);
      c0 = p0_opdone; c1 = p1_opdone;
      tot += int'(c0) + int'(c1);
      @(posedge clk); #1;
      if (tot >= 8) begin
        p0_op = 2'b00; p1_op = 2'b00;
      end else begin
        if (c0) begin t0 = t0 + 1'b1; present(0, 2'b01, t0, 32'h0); end
        if (c1) begin t1 = t1 + 1'b1; present(1, 2'b01, t1, 32'h0); end
      end
    end
    tick(2);
    exp_q0.delete(); exp_q1.delete();
    chk("t3_total", tot, 8);
    chk("t3_strobes", acc_q.size(), 8);
`ifdef KICP_ARB_FIXED_PRIO_EN
    chk("t3_p0_count", done_cnt0 - d0, 8);
    chk("t3_p1_count", done_cnt1 - d1, 0);
`else
    chk("t3_p0_count", done_cnt0 - d0, 4);
    chk("t3_p1_count", done_cnt1 - d1, 4);
`endif
    for (int i = 0; i < 8 && i < acc_q.size(); i++) begin
`ifdef KICP_ARB_FIXED_PRIO_EN
      eg = 2'b01;
`else
      eg = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
      chk($sformatf("t3_grant_%0d", i), acc_q[i].gnt, eg);
    end

    // Accelerator sweep: hold op, step address on each opdone
    acc_q.delete();
    for (int a = 0; a < 4; a++) begin
      n = cyc;
      present(1, 2'b01, AW'(a), 32'h0);
      wait_done(1, at);
      chk($sformatf("t4_lat_%0d", a), at - n, 3);
      @(posedge clk); #1;
    end
    p1_op = 2'b00;
    tick(2);
    chk("t4_strobes", acc_q.size(), 4);
    for (int i = 0; i < 4 && i < acc_q.size(); i++)
      chk($sformatf("t4_addr_%0d", i), acc_q[i].addr, AW'(i));

    // Reset during WAIT aborts the access
    d0 = done_cnt0;
    p0_op = 2'b01; p0_addr = AW'(9);
    tick(2);
    reset = 1'b1;
    p0_op = 2'b00;
    @(negedge clk);
    chk("t5_in_wait", {busy, grant}, 3'b101);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t5_after_reset", {grant, sram_en, busy, p0_opdone}, 5'b0);
    tick(6);
    chk("t5_no_opdone", done_cnt0 - d0, 0);
    read_one(0, AW'(9), "t5_read_after_reset_lat");
    tick(2);

    for (int i = 0; i < 2000 && lane_fin < 3; i++) @(posedge clk);
    chk("lanes_finished", lane_fin, 3);
    chk("p0_sb_empty", exp_q0.size(), 0);
    chk("p1_sb_empty", exp_q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // One read-only instance per RD_LATENCY 2..4, port 1 requesting
  for (genvar gl = 2; gl <= 4; gl++) begin : g_lat
    logic [1:0]    l_op;
    logic [AW-1:0] l_addr, l_saddr;
    logic          l_done0, l_done1, l_en, l_we, l_busy;
    logic [31:0]   l_rd0, l_rd1, l_wd, l_srd;
    logic [1:0]    l_gnt;
    logic [31:0]   pipe [gl];
    logic [31:0]   lq[$];

    kicp_sram_arbiter #(.AWIDTH(AW), .RD_LATENCY(gl)) u_dut_lat (
      .clk(clk), .reset(lat_reset),
      .p0_op(2'b00), .p0_addr({AW{1'b0}}), .p0_wdata(32'h0),
      .p1_op(l_op), .p1_addr(l_addr), .p1_wdata(32'h0),
      .p0_opdone(l_done0), .p0_rdata(l_rd0),
      .p1_opdone(l_done1), .p1_rdata(l_rd1),
      .sram_en(l_en), .sram_we(l_we), .sram_addr(l_saddr),
      .sram_wdata(l_wd), .sram_rdata(l_srd),
      .grant(l_gnt), .busy(l_busy)
    );

    always @(posedge clk) begin
      pipe[0] <= (l_en && !l_we) ? init_word(l_saddr) : JUNK;
      for (int k = 1; k < gl; k++) pipe[k] <= pipe[k-1];
    end
    assign l_srd = pipe[gl-1];

    always @(negedge clk) begin
      if (l_done0) chk($sformatf("lat%0d_p0_opdone", gl), l_done0, 1'b0);
      if (l_done1) begin
        if (lq.size() == 0) chk($sformatf("lat%0d_spurious", gl), lq.size(), 1);
        else chk($sformatf("lat%0d_rdata", gl), l_rd1, lq.pop_front());
      end
    end

    initial begin : lane_drv
      int n;
      int at;
      l_op = 2'b00;
      l_addr = '0;
      wait (lat_reset === 1'b0);
      @(posedge clk); #1;
      for (int r = 0; r < 3; r++) begin
        n = cyc;
        l_addr = AW'(5 + r * 3);
        l_op = 2'b01;
        lq.push_back(init_word(l_addr));
        at = -1;
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (l_done1) begin at = cyc; break; end
        end
        chk($sformatf("lat%0d_opdone_cycle", gl), at - n, 2 + gl);
        @(posedge clk); #1;
        l_op = 2'b00;
        @(posedge clk); #1;
      end
      lane_fin++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
